// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, synchronous-read data memory between
// the CPU MEM stage (M0) and a secondary master such as a loader or DMA (M1).
// At most one access is issued per cycle; read data is steered back to the
// master that issued the read, one cycle after its grant.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RR_MODE      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Which master owns the read currently returning from memory.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_M0   = 2'd1,
        TAG_M1   = 2'd2
    } rd_tag_e;

    // Identity of the most recently granted master, used for round-robin.
    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    rd_tag_e           rd_tag_q, rd_tag_d;
    master_e           last_q, last_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              gnt0;
    logic              gnt1;

    // Grant decision: a lone requester always wins; a tie is resolved either
    // by alternation or by M0 priority with a forced M1 grant once M1 has
    // been refused STARVE_LIMIT cycles in a row.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (m0_req && !m1_req) begin
            gnt0 = 1'b1;
        end else if (!m0_req && m1_req) begin
            gnt1 = 1'b1;
        end else if (m0_req && m1_req) begin
            if (RR_MODE != 0) begin
                if (last_q == MST_M1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                if (starve_cnt_q == LIMIT) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Memory-side mux: fields of the granted master, all zero when idle so
    // the bus does not toggle without an access.
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Next-state: read tag for the coming data beat, round-robin pointer,
    // starvation counter, and the held copies of each master's read data.
    always_comb begin
        rd_tag_d     = TAG_NONE;
        last_d       = last_q;
        starve_cnt_d = 4'd0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        if (gnt0) begin
            last_d = MST_M0;
            if (!m0_we) begin
                rd_tag_d = TAG_M0;
            end
        end else if (gnt1) begin
            last_d = MST_M1;
            if (!m1_we) begin
                rd_tag_d = TAG_M1;
            end
        end

        if (RR_MODE == 0 && m1_req && !gnt1) begin
            if (starve_cnt_q == LIMIT) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end

        if (rd_tag_q == TAG_M0) begin
            rdata0_d = mem_rdata;
        end
        if (rd_tag_q == TAG_M1) begin
            rdata1_d = mem_rdata;
        end
    end

    // State registers; reset drops any in-flight read and makes M0 win the
    // first tie by pretending M1 was served last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_tag_q     <= TAG_NONE;
            last_q       <= MST_M1;
            starve_cnt_q <= 4'd0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rd_tag_q     <= rd_tag_d;
            last_q       <= last_d;
            starve_cnt_q <= starve_cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Return path: the valid strobe is a decode of the registered tag, and
    // data is taken straight from memory during the beat, held afterwards.
    always_comb begin
        m0_rvalid = (rd_tag_q == TAG_M0);
        m1_rvalid = (rd_tag_q == TAG_M1);
        m0_rdata  = (rd_tag_q == TAG_M0) ? mem_rdata : rdata0_q;
        m1_rdata  = (rd_tag_q == TAG_M1) ? mem_rdata : rdata1_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. One instance runs in
// round-robin mode, the other in M0-priority mode with a starvation limit of
// 4; both share the master inputs and a simple synchronous-read memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;

    logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid;
    logic [31:0] rr_m0_rdata, rr_m1_rdata;
    logic        rr_mem_en, rr_mem_we;
    logic [31:0] rr_mem_addr, rr_mem_wdata;
    logic [31:0] rr_mem_rdata = '0;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_mem_en, fp_mem_we;
    logic [31:0] fp_mem_addr, fp_mem_wdata;
    logic [31:0] fp_mem_rdata = '0;

    logic [31:0] mem [256];
    logic        init_pending = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(1), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
        .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(0), .STARVE_LIMIT(4)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
    );

    // Shared memory: word at byte address A initially holds 0xA0000000|A.
    // Writes come through the round-robin instance (both see identical stores).
    always @(posedge clk) begin
        if (init_pending) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i * 4);
            init_pending <= 1'b0;
        end else begin
            if (rr_mem_en && rr_mem_we)  mem[rr_mem_addr[9:2]] <= rr_mem_wdata;
            if (rr_mem_en && !rr_mem_we) rr_mem_rdata <= mem[rr_mem_addr[9:2]];
            if (fp_mem_en && !fp_mem_we) fp_mem_rdata <= mem[fp_mem_addr[9:2]];
        end
    end

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rr_m0_rvalid, rr_m1_rvalid, fp_m0_rvalid, fp_m1_rvalid} !== 4'b0000)
            $display("FAIL reset_rvalid: got %b expected 0000", {rr_m0_rvalid, rr_m1_rvalid, fp_m0_rvalid, fp_m1_rvalid});
        else n_pass++;
        n_checks++;
        if (rr_m0_rdata !== 32'h0 || rr_m1_rdata !== 32'h0)
            $display("FAIL reset_rdata: got %h/%h expected 0/0", rr_m0_rdata, rr_m1_rdata);
        else n_pass++;
        n_checks++;
        if ({rr_mem_en, rr_mem_we, rr_m0_gnt, rr_m1_gnt} !== 4'b0000 || rr_mem_addr !== 32'h0)
            $display("FAIL reset_idle_bus: got en/we/g0/g1=%b addr=%h expected 0000/0",
                     {rr_mem_en, rr_mem_we, rr_m0_gnt, rr_m1_gnt}, rr_mem_addr);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_store_load;
        @(negedge clk);
        set_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        n_checks++;
        if (rr_m0_gnt !== 1'b1 || rr_m1_gnt !== 1'b0 || rr_mem_we !== 1'b1 ||
            rr_mem_addr !== 32'h10 || rr_mem_wdata !== 32'hDEADBEEF)
            $display("FAIL store_grant: got g0=%b g1=%b we=%b addr=%h wd=%h expected 1 0 1 10 deadbeef",
                     rr_m0_gnt, rr_m1_gnt, rr_mem_we, rr_mem_addr, rr_mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rr_m0_rvalid !== 1'b0)
            $display("FAIL store_no_rvalid: got %b expected 0", rr_m0_rvalid);
        else n_pass++;
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        n_checks++;
        if (rr_m0_gnt !== 1'b1 || rr_mem_en !== 1'b1 || rr_mem_we !== 1'b0)
            $display("FAIL load_grant: got g0=%b en=%b we=%b expected 1 1 0", rr_m0_gnt, rr_mem_en, rr_mem_we);
        else n_pass++;
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (rr_m0_rvalid !== 1'b1 || rr_m0_rdata !== 32'hDEADBEEF || rr_m1_rvalid !== 1'b0)
            $display("FAIL load_return: got v0=%b d0=%h v1=%b expected 1 deadbeef 0",
                     rr_m0_rvalid, rr_m0_rdata, rr_m1_rvalid);
        else n_pass++;
        #1;
        n_checks++;
        if (rr_mem_en !== 1'b0 || rr_mem_addr !== 32'h0 || rr_mem_wdata !== 32'h0)
            $display("FAIL idle_bus_zero: got en=%b addr=%h wd=%h expected 0 0 0", rr_mem_en, rr_mem_addr, rr_mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rr_m0_rvalid !== 1'b0 || rr_m0_rdata !== 32'hDEADBEEF)
            $display("FAIL rdata_hold: got v0=%b d0=%h expected 0 deadbeef", rr_m0_rvalid, rr_m0_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_m1(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        n_checks++;
        if (rr_m1_gnt !== 1'b1 || rr_m0_gnt !== 1'b0 || rr_mem_addr !== 32'h20)
            $display("FAIL b2b_grant0: got g1=%b g0=%b addr=%h expected 1 0 20", rr_m1_gnt, rr_m0_gnt, rr_mem_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rr_m1_rvalid !== 1'b1 || rr_m1_rdata !== 32'hA000_0020 || rr_m0_rvalid !== 1'b0)
            $display("FAIL b2b_data0: got v1=%b d1=%h v0=%b expected 1 a0000020 0", rr_m1_rvalid, rr_m1_rdata, rr_m0_rvalid);
        else n_pass++;
        set_m1(1'b1, 1'b0, 32'h24, 32'h0);
        #1;
        n_checks++;
        if (rr_m1_gnt !== 1'b1 || rr_mem_addr !== 32'h24)
            $display("FAIL b2b_grant1: got g1=%b addr=%h expected 1 24", rr_m1_gnt, rr_mem_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rr_m1_rvalid !== 1'b1 || rr_m1_rdata !== 32'hA000_0024)
            $display("FAIL b2b_data1: got v1=%b d1=%h expected 1 a0000024", rr_m1_rvalid, rr_m1_rdata);
        else n_pass++;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (rr_m1_rvalid !== 1'b0 || rr_m1_rdata !== 32'hA000_0024)
            $display("FAIL b2b_end: got v1=%b d1=%h expected 0 a0000024", rr_m1_rvalid, rr_m1_rdata);
        else n_pass++;
    endtask

    // The previous test left M1 as last served, so the first tie goes to M0.
    task automatic test_rr_contention;
        logic exp_m0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ((i - 1) % 2 == 0) begin
                    if (rr_m0_rvalid !== 1'b1 || rr_m1_rvalid !== 1'b0 || rr_m0_rdata !== 32'hA000_0040)
                        $display("FAIL rr_return_%0d: got v0=%b v1=%b d0=%h expected 1 0 a0000040",
                                 i - 1, rr_m0_rvalid, rr_m1_rvalid, rr_m0_rdata);
                    else n_pass++;
                end else begin
                    if (rr_m1_rvalid !== 1'b1 || rr_m0_rvalid !== 1'b0 || rr_m1_rdata !== 32'hA000_0080)
                        $display("FAIL rr_return_%0d: got v1=%b v0=%b d1=%h expected 1 0 a0000080",
                                 i - 1, rr_m1_rvalid, rr_m0_rvalid, rr_m1_rdata);
                    else n_pass++;
                end
            end
            if (i == 0) begin
                set_m0(1'b1, 1'b0, 32'h40, 32'h0);
                set_m1(1'b1, 1'b0, 32'h80, 32'h0);
            end
            #1;
            exp_m0 = (i % 2 == 0);
            n_checks++;
            if (rr_m0_gnt !== exp_m0 || rr_m1_gnt !== !exp_m0 ||
                rr_mem_addr !== (exp_m0 ? 32'h40 : 32'h80))
                $display("FAIL rr_grant_%0d: got g0=%b g1=%b addr=%h expected g0=%b", i,
                         rr_m0_gnt, rr_m1_gnt, rr_mem_addr, exp_m0);
            else n_pass++;
        end
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (rr_m1_rvalid !== 1'b1 || rr_m1_rdata !== 32'hA000_0080)
            $display("FAIL rr_return_5: got v1=%b d1=%h expected 1 a0000080", rr_m1_rvalid, rr_m1_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    // M0 wins four ties, the fifth goes to M1, then the pattern restarts.
    task automatic test_fixed_priority;
        logic exp_m1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                set_m0(1'b1, 1'b0, 32'h40, 32'h0);
                set_m1(1'b1, 1'b0, 32'h80, 32'h0);
            end
            #1;
            exp_m1 = (i % 5 == 4);
            n_checks++;
            if (fp_m1_gnt !== exp_m1 || fp_m0_gnt !== !exp_m1)
                $display("FAIL fp_grant_%0d: got g0=%b g1=%b expected g1=%b", i, fp_m0_gnt, fp_m1_gnt, exp_m1);
            else n_pass++;
        end
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (fp_m1_rvalid !== 1'b1 || fp_m1_rdata !== 32'hA000_0080)
            $display("FAIL fp_m1_return: got v1=%b d1=%h expected 1 a0000080", fp_m1_rvalid, fp_m1_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        n_checks++;
        if (rr_m0_gnt !== 1'b1)
            $display("FAIL midrst_grant: got %b expected 1", rr_m0_gnt);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (rr_m0_rvalid !== 1'b0 || fp_m0_rvalid !== 1'b0 || rr_m0_rdata !== 32'h0)
            $display("FAIL midrst_during: got v0=%b fpv0=%b d0=%h expected 0 0 0", rr_m0_rvalid, fp_m0_rvalid, rr_m0_rdata);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (rr_m0_rvalid !== 1'b0 || rr_m1_rvalid !== 1'b0)
            $display("FAIL midrst_release: got v0=%b v1=%b expected 0 0", rr_m0_rvalid, rr_m1_rvalid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rr_m0_rvalid !== 1'b0 || fp_m0_rvalid !== 1'b0)
            $display("FAIL midrst_after: got v0=%b fpv0=%b expected 0 0", rr_m0_rvalid, fp_m0_rvalid);
        else n_pass++;
        set_m0(1'b1, 1'b0, 32'h40, 32'h0);
        set_m1(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        n_checks++;
        if (rr_m0_gnt !== 1'b1 || rr_m1_gnt !== 1'b0)
            $display("FAIL midrst_tie: got g0=%b g1=%b expected 1 0", rr_m0_gnt, rr_m1_gnt);
        else n_pass++;
        @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (rr_m0_rvalid !== 1'b1 || rr_m0_rdata !== 32'hA000_0040)
            $display("FAIL midrst_next_read: got v0=%b d0=%h expected 1 a0000040", rr_m0_rvalid, rr_m0_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_rr_contention();
        test_fixed_priority();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
